// File: rtl/axi_lite_mem_arbiter.sv
// Single-outstanding AXI4-Lite arbiter: IFU (M0, read-only) and LSU (M1, read/write) share one bus port.
// Optional macro AXI_ARB_ROUND_ROBIN_EN alternates M0/M1 reads; otherwise fixed priority M1 write > M1 read > M0 read.
module axi_lite_mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   // M0: instruction fetch, read only
   input  logic                m0_arvalid,
   input  logic [ADDR_W-1:0]   m0_araddr,
   output logic                m0_arready,
   output logic                m0_rvalid,
   output logic [DATA_W-1:0]   m0_rdata,
   output logic [1:0]          m0_rresp,
   input  logic                m0_rready,
   // M1: load/store
   input  logic                m1_arvalid,
   input  logic [ADDR_W-1:0]   m1_araddr,
   output logic                m1_arready,
   output logic                m1_rvalid,
   output logic [DATA_W-1:0]   m1_rdata,
   output logic [1:0]          m1_rresp,
   input  logic                m1_rready,
   input  logic                m1_awvalid,
   input  logic [ADDR_W-1:0]   m1_awaddr,
   output logic                m1_awready,
   input  logic                m1_wvalid,
   input  logic [DATA_W-1:0]   m1_wdata,
   input  logic [DATA_W/8-1:0] m1_wstrb,
   output logic                m1_wready,
   output logic                m1_bvalid,
   output logic [1:0]          m1_bresp,
   input  logic                m1_bready,
   // Bus master port
   output logic                s_arvalid,
   output logic [ADDR_W-1:0]   s_araddr,
   input  logic                s_arready,
   input  logic                s_rvalid,
   input  logic [DATA_W-1:0]   s_rdata,
   input  logic [1:0]          s_rresp,
   output logic                s_rready,
   output logic                s_awvalid,
   output logic [ADDR_W-1:0]   s_awaddr,
   input  logic                s_awready,
   output logic                s_wvalid,
   output logic [DATA_W-1:0]   s_wdata,
   output logic [DATA_W/8-1:0] s_wstrb,
   input  logic                s_wready,
   input  logic                s_bvalid,
   input  logic [1:0]          s_bresp,
   output logic                s_bready,
   output logic [1:0]          grant
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RD_M0 = 2'b01,
      RD_M1 = 2'b10,
      WR_M1 = 2'b11
   } state_e;

   state_e state_q, state_d;
   logic   ar_done_q, ar_done_d;
   logic   aw_done_q, aw_done_d;
   logic   w_done_q,  w_done_d;
   logic   wr_req, pick_m1;

   assign wr_req = m1_awvalid | m1_wvalid;
   assign grant  = state_q;

`ifdef AXI_ARB_ROUND_ROBIN_EN
   // last_q: 1 when M1 owned the most recent read grant
   logic last_q, last_d;
   assign pick_m1 = m1_arvalid & (~m0_arvalid | ~last_q);

   always_ff @(posedge clk) begin
      if (rst) last_q <= 1'b0;
      else     last_q <= last_d;
   end
`else
   assign pick_m1 = m1_arvalid;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         ar_done_q <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         ar_done_q <= ar_done_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      ar_done_d  = ar_done_q;
      aw_done_d  = aw_done_q;
      w_done_d   = w_done_q;
`ifdef AXI_ARB_ROUND_ROBIN_EN
      last_d     = last_q;
`endif
      m0_arready = 1'b0;
      m0_rvalid  = 1'b0;
      m0_rdata   = '0;
      m0_rresp   = '0;
      m1_arready = 1'b0;
      m1_rvalid  = 1'b0;
      m1_rdata   = '0;
      m1_rresp   = '0;
      m1_awready = 1'b0;
      m1_wready  = 1'b0;
      m1_bvalid  = 1'b0;
      m1_bresp   = '0;
      s_arvalid  = 1'b0;
      s_araddr   = '0;
      s_rready   = 1'b0;
      s_awvalid  = 1'b0;
      s_awaddr   = '0;
      s_wvalid   = 1'b0;
      s_wdata    = '0;
      s_wstrb    = '0;
      s_bready   = 1'b0;

      case (state_q)
         IDLE: begin
            ar_done_d = 1'b0;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            if (wr_req) begin
               state_d = WR_M1;
            end else if (pick_m1) begin
               state_d = RD_M1;
`ifdef AXI_ARB_ROUND_ROBIN_EN
               last_d  = 1'b1;
`endif
            end else if (m0_arvalid) begin
               state_d = RD_M0;
`ifdef AXI_ARB_ROUND_ROBIN_EN
               last_d  = 1'b0;
`endif
            end
         end
         RD_M0: begin
            // Only one AR per grant: address channel closes after its handshake
            s_arvalid  = m0_arvalid & ~ar_done_q;
            s_araddr   = m0_araddr;
            m0_arready = s_arready & ~ar_done_q;
            m0_rvalid  = s_rvalid;
            m0_rdata   = s_rdata;
            m0_rresp   = s_rresp;
            s_rready   = m0_rready;
            if (m0_arvalid & s_arready & ~ar_done_q) ar_done_d = 1'b1;
            if (s_rvalid & m0_rready)                state_d   = IDLE;
         end
         RD_M1: begin
            s_arvalid  = m1_arvalid & ~ar_done_q;
            s_araddr   = m1_araddr;
            m1_arready = s_arready & ~ar_done_q;
            m1_rvalid  = s_rvalid;
            m1_rdata   = s_rdata;
            m1_rresp   = s_rresp;
            s_rready   = m1_rready;
            if (m1_arvalid & s_arready & ~ar_done_q) ar_done_d = 1'b1;
            if (s_rvalid & m1_rready)                state_d   = IDLE;
         end
         WR_M1: begin
            // AW and W complete independently, in either order
            s_awvalid  = m1_awvalid & ~aw_done_q;
            s_awaddr   = m1_awaddr;
            m1_awready = s_awready & ~aw_done_q;
            s_wvalid   = m1_wvalid & ~w_done_q;
            s_wdata    = m1_wdata;
            s_wstrb    = m1_wstrb;
            m1_wready  = s_wready & ~w_done_q;
            m1_bvalid  = s_bvalid;
            m1_bresp   = s_bresp;
            s_bready   = m1_bready;
            if (m1_awvalid & s_awready & ~aw_done_q) aw_done_d = 1'b1;
            if (m1_wvalid & s_wready & ~w_done_q)    w_done_d  = 1'b1;
            if (s_bvalid & m1_bready)                state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_axi_lite_mem_arbiter.sv
// Bench for axi_lite_mem_arbiter: reactive bus slave model plus read/write response scoreboards.
module tb_axi_lite_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   always #5 clk = ~clk;

   logic        m0_arvalid = 0, m0_arready, m0_rvalid, m0_rready = 0;
   logic [31:0] m0_araddr = 0, m0_rdata;
   logic [1:0]  m0_rresp;
   logic        m1_arvalid = 0, m1_arready, m1_rvalid, m1_rready = 0;
   logic [31:0] m1_araddr = 0, m1_rdata;
   logic [1:0]  m1_rresp;
   logic        m1_awvalid = 0, m1_awready, m1_wvalid = 0, m1_wready;
   logic [31:0] m1_awaddr = 0, m1_wdata = 0;
   logic [3:0]  m1_wstrb = 0;
   logic        m1_bvalid, m1_bready = 0;
   logic [1:0]  m1_bresp;
   logic        s_arvalid, s_arready = 1, s_rvalid = 0, s_rready;
   logic [31:0] s_araddr, s_rdata = 0;
   logic [1:0]  s_rresp = 0;
   logic        s_awvalid, s_awready = 1, s_wvalid, s_wready = 1;
   logic [31:0] s_awaddr, s_wdata;
   logic [3:0]  s_wstrb;
   logic        s_bvalid = 0, s_bready;
   logic [1:0]  s_bresp = 0;
   logic [1:0]  grant;

   axi_lite_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .m0_arvalid(m0_arvalid), .m0_araddr(m0_araddr), .m0_arready(m0_arready),
      .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rready(m0_rready),
      .m1_arvalid(m1_arvalid), .m1_araddr(m1_araddr), .m1_arready(m1_arready),
      .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rready(m1_rready),
      .m1_awvalid(m1_awvalid), .m1_awaddr(m1_awaddr), .m1_awready(m1_awready),
      .m1_wvalid(m1_wvalid), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wready(m1_wready),
      .m1_bvalid(m1_bvalid), .m1_bresp(m1_bresp), .m1_bready(m1_bready),
      .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arready(s_arready),
      .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rready(s_rready),
      .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awready(s_awready),
      .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wready(s_wready),
      .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bready(s_bready),
      .grant(grant)
   );

   int n_chk = 0, n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Slave memory contents and error map
   function automatic logic [31:0] fdata(input logic [31:0] a);
      return (a == 32'h8000_0000) ? 32'hDEAD_BEEF : {a[15:0] ^ 16'h5A5A, a[31:16]};
   endfunction
   function automatic logic [1:0] fresp(input logic [31:0] a);
      return (a[31:28] == 4'hE) ? 2'b10 : 2'b00;
   endfunction

   function automatic logic [31:0] vr();
      return {20'd0, s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready,
              m0_arready, m0_rvalid, m1_arready, m1_rvalid, m1_awready, m1_wready, m1_bvalid};
   endfunction

   typedef struct {
      bit          port;
      logic [31:0] data;
      logic [1:0]  resp;
   } rexp_t;
   rexp_t      rq[$];
   logic [1:0] bq[$];
   logic [1:0] gtrace[$];
   bit         rec = 0, chk_m0_blk = 0;

   // Bus slave: R after sl_rlat cycles, B one cycle after both AW and W
   int          sl_rlat = 1, sl_cnt = 0, cyc = 0, ar_cnt = 0, aw_cyc = 0, w_cyc = 0;
   bit          r_pend = 0, got_aw = 0, got_w = 0;
   bit          ar_hs, r_hs, aw_hs, w_hs, b_hs, rst_s;
   logic [31:0] raddr = 0, cap_awaddr = 0, cap_wdata = 0;
   logic [3:0]  cap_wstrb = 0;
   logic [1:0]  sl_bresp = 2'b00;

   always begin
      @(negedge clk);
      rst_s = rst;
      ar_hs = s_arvalid && s_arready;
      r_hs  = s_rvalid && s_rready;
      aw_hs = s_awvalid && s_awready;
      w_hs  = s_wvalid && s_wready;
      b_hs  = s_bvalid && s_bready;
      if (ar_hs) begin raddr = s_araddr; ar_cnt++; end
      if (aw_hs) begin cap_awaddr = s_awaddr; aw_cyc = cyc; end
      if (w_hs)  begin cap_wdata = s_wdata; cap_wstrb = s_wstrb; w_cyc = cyc; end
      @(posedge clk);
      cyc++;
      #1;
      if (rst_s) begin
         s_rvalid = 0; s_bvalid = 0; r_pend = 0; got_aw = 0; got_w = 0;
         s_rdata = 0; s_rresp = 0; s_bresp = 0;
      end else begin
         if (r_hs) s_rvalid = 0;
         if (ar_hs) begin r_pend = 1; sl_cnt = sl_rlat; end
         if (r_pend) begin
            if (sl_cnt <= 1) begin
               s_rvalid = 1; s_rdata = fdata(raddr); s_rresp = fresp(raddr); r_pend = 0;
            end else sl_cnt--;
         end
         if (b_hs) s_bvalid = 0;
         if (aw_hs) got_aw = 1;
         if (w_hs)  got_w = 1;
         if (got_aw && got_w && !s_bvalid) begin
            s_bvalid = 1; s_bresp = sl_bresp; got_aw = 0; got_w = 0;
         end
      end
   end

   task automatic chk_r(input bit p, input logic [31:0] d, input logic [1:0] r);
      rexp_t e;
      if (rq.size() == 0) chk("r_unexpected", 32'd1, 32'd0);
      else begin
         e = rq.pop_front();
         chk("r_port", 32'(p), 32'(e.port));
         chk("r_data", d, e.data);
         chk("r_resp", 32'(r), 32'(e.resp));
      end
   endtask

   // Response monitor / scoreboard
   always @(negedge clk) begin
      if (!rst) begin
         if (m0_rvalid && m0_rready) chk_r(1'b0, m0_rdata, m0_rresp);
         if (m1_rvalid && m1_rready) chk_r(1'b1, m1_rdata, m1_rresp);
         if (m1_bvalid && m1_bready) begin
            if (bq.size() == 0) chk("b_unexpected", 32'd1, 32'd0);
            else chk("bresp", 32'(m1_bresp), 32'(bq.pop_front()));
         end
         if (grant == 2'b11) chk("bvalid_mirror", 32'(m1_bvalid), 32'(s_bvalid));
         if (chk_m0_blk && grant == 2'b11) chk("m0_arready_blocked", 32'(m0_arready), 32'd0);
         if (rec) gtrace.push_back(grant);
      end
   end

   task automatic m_ar(input bit p, input logic [31:0] a);
      int n;
      if (p) begin m1_araddr = a; m1_arvalid = 1; end
      else   begin m0_araddr = a; m0_arvalid = 1; end
      for (n = 0; n < 300; n++) begin
         @(negedge clk);
         if (p ? m1_arready : m0_arready) break;
      end
      chk(p ? "m1_ar_hs" : "m0_ar_hs", 32'(n < 300), 32'd1);
      @(posedge clk); #1;
      if (p) begin m1_arvalid = 0; m1_araddr = 0; end
      else   begin m0_arvalid = 0; m0_araddr = 0; end
   endtask

   task automatic m1_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int aw_dly);
      fork
         begin
            int n;
            m1_wdata = d; m1_wstrb = s; m1_wvalid = 1;
            for (n = 0; n < 300; n++) begin @(negedge clk); if (m1_wready) break; end
            chk("m1_w_hs", 32'(n < 300), 32'd1);
            @(posedge clk); #1;
            m1_wvalid = 0; m1_wdata = 0; m1_wstrb = 0;
         end
         begin
            int n;
            if (aw_dly > 0) begin repeat (aw_dly) @(posedge clk); #1; end
            m1_awaddr = a; m1_awvalid = 1;
            for (n = 0; n < 300; n++) begin @(negedge clk); if (m1_awready) break; end
            chk("m1_aw_hs", 32'(n < 300), 32'd1);
            @(posedge clk); #1;
            m1_awvalid = 0; m1_awaddr = 0;
         end
      join
   endtask

   task automatic wait_done();
      int n;
      for (n = 0; n < 300; n++) begin
         @(negedge clk);
         if (rq.size() == 0 && bq.size() == 0 && grant == 2'b00 && !r_pend && !s_rvalid && !s_bvalid) break;
      end
      chk("done", 32'(n < 300), 32'd1);
      @(posedge clk); #1;
   endtask

   initial begin
      int          n, ar0;
      logic [1:0]  gv[$];
      int          gl[$];

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_vr", vr(), 32'd0);
      chk("rst_addr", s_araddr | s_awaddr | s_wdata, 32'd0);
      @(posedge clk); #1;
      rst = 0; m0_rready = 1; m1_rready = 1; m1_bready = 1;

      // M0 alone: one cycle of arbitration, grant drops after R handshake
      rq.push_back('{1'b0, 32'hDEAD_BEEF, 2'b00});
      fork
         m_ar(1'b0, 32'h8000_0000);
         begin
            @(negedge clk); chk("t1_arb_cycle", 32'(grant), 32'd0);
            @(negedge clk); chk("t1_grant_m0", 32'(grant), 32'd1);
         end
      join
      for (n = 0; n < 50; n++) begin @(negedge clk); if (m0_rvalid) break; end
      chk("t1_r_seen", 32'(n < 50), 32'd1);
      @(negedge clk); chk("t1_grant_idle", 32'(grant), 32'd0);
      @(posedge clk); #1;

      // M1 write, W handshake two cycles ahead of AW
      bq.push_back(2'b00);
      m1_wr(32'h8000_1004, 32'h1234_5678, 4'hF, 3);
      wait_done();
      chk("t2_awaddr", cap_awaddr, 32'h8000_1004);
      chk("t2_wdata", cap_wdata, 32'h1234_5678);
      chk("t2_wstrb", 32'(cap_wstrb), 32'hF);
      chk("t2_aw_after_w", 32'(aw_cyc - w_cyc), 32'd2);

      // Tie between reads: M1 first
      rq.push_back('{1'b1, fdata(32'h8000_2000), 2'b00});
      rq.push_back('{1'b0, fdata(32'h8000_0040), 2'b00});
      fork
         m_ar(1'b0, 32'h8000_0040);
         m_ar(1'b1, 32'h8000_2000);
      join
      wait_done();

      // M0 waits while M1 issues two back-to-back reads
      ar0 = ar_cnt;
      rq.push_back('{1'b1, fdata(32'h8000_3000), 2'b00});
`ifdef AXI_ARB_ROUND_ROBIN_EN
      rq.push_back('{1'b0, fdata(32'h8000_0080), 2'b00});
      rq.push_back('{1'b1, fdata(32'h8000_3004), 2'b00});
`else
      rq.push_back('{1'b1, fdata(32'h8000_3004), 2'b00});
      rq.push_back('{1'b0, fdata(32'h8000_0080), 2'b00});
`endif
      fork
         m_ar(1'b0, 32'h8000_0080);
         begin m_ar(1'b1, 32'h8000_3000); m_ar(1'b1, 32'h8000_3004); end
      join
      wait_done();
      chk("t3_ar_count", 32'(ar_cnt - ar0), 32'd3);

      // Write beats a simultaneous M0 read; M0 follows after one idle cycle
      rq.push_back('{1'b0, fdata(32'h8000_0100), 2'b00});
      bq.push_back(2'b01);
      sl_bresp = 2'b01;
      rec = 1; chk_m0_blk = 1;
      fork
         m_ar(1'b0, 32'h8000_0100);
         m1_wr(32'h8000_4000, 32'hCAFE_F00D, 4'h3, 0);
      join
      wait_done();
      rec = 0; chk_m0_blk = 0; sl_bresp = 2'b00;
      foreach (gtrace[i]) begin
         if (gv.size() == 0 || gv[gv.size()-1] != gtrace[i]) begin gv.push_back(gtrace[i]); gl.push_back(1); end
         else gl[gl.size()-1]++;
      end
      chk("t4_runs", 32'(gv.size()), 32'd5);
      if (gv.size() == 5) begin
         chk("t4_first_owner", 32'(gv[1]), 32'd3);
         chk("t4_second_owner", 32'(gv[3]), 32'd1);
         chk("t4_idle_gap", 32'(gl[2]), 32'd1);
      end

      // SLVERR on an M1 read passes through unmodified
      rq.push_back('{1'b1, fdata(32'hE000_0010), 2'b10});
      m_ar(1'b1, 32'hE000_0010);
      wait_done();

      // Reset while an M0 read response is outstanding
      sl_rlat = 5;
      m_ar(1'b0, 32'h8000_0200);
      chk("t6_pre_grant", 32'(grant), 32'd1);
      rst = 1;
      @(posedge clk);
      @(negedge clk);
      chk("t6_rst_grant", 32'(grant), 32'd0);
      chk("t6_rst_vr", vr(), 32'd0);
      @(posedge clk); #1;
      rst = 0; sl_rlat = 1;
      rq.push_back('{1'b0, fdata(32'h8000_0204), 2'b00});
      m_ar(1'b0, 32'h8000_0204);
      wait_done();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
